// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Start/done handshake; results hold until the next accepted start.
// Optional macro DIV_SIGNED_EN: two's complement operands, truncating division.
module seq_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH-1:0]   r_dvd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dbz;
  logic               w_accept;
  logic               w_div_zero;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_sub;
  logic               w_ge;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_div_zero = (divisor == '0);

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  // Magnitudes of the operands; MIN maps onto itself, which is correct unsigned
  assign w_dvd_mag = dividend[WIDTH-1] ? (-dividend) : dividend;
  assign w_dvs_mag = divisor[WIDTH-1]  ? (-divisor)  : divisor;
  assign w_q_fix   = r_neg_q ? (-r_q)   : r_q;
  assign w_r_fix   = r_neg_r ? (-r_rem) : r_rem;
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_q_fix   = r_q;
  assign w_r_fix   = r_rem;
`endif

  // Trial subtraction on the shifted partial remainder
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_sub   = w_shift[WIDTH-1:0] - r_div;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_accept) w_next = w_div_zero ? S_FIN : S_CALC;
      S_CALC:         if (r_cnt == CNT_W'(1)) w_next = S_FIN;
      S_FIN:          w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  // Operand capture and one restoring iteration per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
      r_q   <= '0;
      r_div <= '0;
      r_dvd <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else if (w_accept) begin
      r_rem <= '0;
      r_q   <= w_dvd_mag;
      r_div <= w_dvs_mag;
      r_dvd <= dividend;
      r_cnt <= CNT_W'(WIDTH);
      r_dbz <= w_div_zero;
`ifdef DIV_SIGNED_EN
      r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_r <= dividend[WIDTH-1];
`endif
    end else if (r_state == S_CALC) begin
      r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
      r_q   <= {r_q[WIDTH-2:0], w_ge};
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Registered handshake and result outputs; results load only in FIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      ready <= (w_next == S_IDLE) || (w_next == S_DONE);
      busy  <= (w_next == S_CALC) || (w_next == S_FIN);
      done  <= (r_state == S_FIN);
      if (r_state == S_FIN) begin
        div_by_zero <= r_dbz;
        if (r_dbz) begin
          quotient  <= '1;
          remainder <= r_dvd;
        end else begin
          quotient  <= w_q_fix;
          remainder <= w_r_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven vectors through a scoreboard, plus hand-written
// sequences for back-to-back, ignored start and mid-operation reset.
module tb_seq_divider;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LAT   = WIDTH + 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  seq_divider #(.WIDTH(WIDTH), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .ready(ready), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    int               done_cyc;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   busy_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every done pulse pops one expected result
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("quotient",    64'(quotient),    64'(e.q));
          check("remainder",   64'(remainder),   64'(e.r));
          check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          check("done_cycle",  64'(cyc),         64'(e.done_cyc));
          check("busy_cycles", 64'(busy_cnt),    64'(e.lat));
        end
        busy_cnt = 0;
      end
    end
  end

  // Drive a start from the current negedge and register its expected result
  task automatic launch(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs,
                        input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                        input logic edbz);
    exp_t e;
    int   t0;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    t0       = cyc;
    @(posedge clk);
    e.q        = eq;
    e.r        = er;
    e.dbz      = edbz;
    e.lat      = (dvs == '0) ? 1 : int'(LAT);
    e.done_cyc = t0 + 1 + e.lat;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic do_op(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs,
                       input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                       input logic edbz);
    @(negedge clk);
    launch(dvd, dvs, eq, er, edbz);
  endtask

  // Bounded wait for every pending result to be produced
  task automatic wait_quiet();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  vec_t tbl[11];

  initial begin
`ifdef DIV_SIGNED_EN
    tbl[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1]  = '{-32'sd100,      32'd7,          -32'sd14,       -32'sd2,        1'b0};
    tbl[2]  = '{32'd100,        -32'sd7,        -32'sd14,       32'd2,          1'b0};
    tbl[3]  = '{-32'sd100,      -32'sd7,        32'd14,         -32'sd2,        1'b0};
    tbl[4]  = '{-32'sd7,        32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    tbl[5]  = '{32'd7,          -32'sd2,        32'hFFFFFFFD,   32'd1,          1'b0};
    tbl[6]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    tbl[7]  = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    tbl[8]  = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    tbl[9]  = '{-32'sd7,        32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1};
    tbl[10] = '{32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0};
`else
    tbl[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    tbl[2]  = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    tbl[3]  = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    tbl[4]  = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    tbl[5]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    tbl[6]  = '{32'h80000000,   32'd3,          32'd715827882,  32'd2,          1'b0};
    tbl[7]  = '{32'd12345678,   32'd1000,       32'd12345,      32'd678,        1'b0};
    tbl[8]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    tbl[9]  = '{32'd7,          32'd8,          32'd0,          32'd7,          1'b0};
    tbl[10] = '{32'hDEADBEEF,   32'h10,         32'h0DEADBEE,   32'hF,          1'b0};
`endif

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",    64'(ready),       64'd1);
    check("rst_busy",     64'(busy),        64'd0);
    check("rst_done",     64'(done),        64'd0);
    check("rst_quotient", 64'(quotient),    64'd0);
    check("rst_dbz",      64'(div_by_zero), 64'd0);
    rst = 1'b0;

    // Table vectors, one operation at a time
    for (int i = 0; i < 11; i++) begin
      do_op(tbl[i].dvd, tbl[i].dvs, tbl[i].q, tbl[i].r, tbl[i].dbz);
      wait_quiet();
    end

    // Back-to-back: second start asserted in the done cycle of the first
    do_op(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
    begin
      int n = 0;
      while (done !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("b2b_done_seen", 64'(done), 64'd1);
      check("b2b_ready",     64'(ready), 64'd1);
      launch(32'd3, 32'd10, 32'd0, 32'd3, 1'b0);
      check("b2b_old_held", 64'(quotient), 64'hFFFFFFFF);
    end
    wait_quiet();
    repeat (5) @(negedge clk);
    check("hold_quotient",  64'(quotient),  64'd0);
    check("hold_remainder", 64'(remainder), 64'd3);

    // Start re-pulsed while busy is ignored
    do_op(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    check("busy_mid", 64'(ready), 64'd0);
    dividend = 32'd7;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_quiet();

    // Reset in the middle of a calculation abandons it
    do_op(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_quotient",  64'(quotient),    64'd0);
    check("midrst_remainder", 64'(remainder),   64'd0);
    check("midrst_ready",     64'(ready),       64'd1);
    check("midrst_busy",      64'(busy),        64'd0);
    check("midrst_done",      64'(done),        64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_ready", 64'(ready), 64'd1);
    do_op(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    wait_quiet();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
